// File: rtl/fingering_prompter.sv
// Practice sequencer: reads a song of note codes from an external ROM,
// presents each target's valves and airflow, and scores the player's note.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             pulse: start or restart a song (from IDLE or DONE)
//   song_addr         registered ROM address
//   song_note         ROM data for song_addr, same cycle
//   player_note       note code the player is currently producing
//   target_note       current target code (0 in IDLE/DONE)
//   target_keys       valves to press, bit 2 = valve 1
//   target_airflow    airflow level for the target
//   hit, miss         one-cycle scoring pulses
//   hits, misses      saturating score counters
//   busy              high in FETCH, WAIT_MATCH and NEXT
//   done              high in DONE
module fingering_prompter #(
    parameter int ADDR_W         = 3,
    parameter int SONG_LEN       = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [4:0]        song_note,
    input  logic [4:0]        player_note,
    output logic [4:0]        target_note,
    output logic [2:0]        target_keys,
    output logic [1:0]        target_airflow,
    output logic              hit,
    output logic              miss,
    output logic [7:0]        hits,
    output logic [7:0]        misses,
    output logic              busy,
    output logic              done
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TIME_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [TIME_W-1:0] timer_q, timer_d, timer_inc;

    logic [ADDR_W-1:0] addr_d;
    logic [4:0]        tnote_d;
    logic [2:0]        tkeys_d;
    logic [1:0]        tair_d;
    logic              hit_d, miss_d;
    logic [7:0]        hits_d, misses_d;
    logic              busy_d, done_d;

    // Returns {airflow, keys}; terminators map to all zeros.
    function automatic logic [4:0] map_note(input logic [4:0] n);
        logic [4:0] r;
        case (n)
            5'd1:    r = 5'b01_000;
            5'd2:    r = 5'b01_111;
            5'd3:    r = 5'b01_101;
            5'd4:    r = 5'b01_011;
            5'd5:    r = 5'b01_110;
            5'd6:    r = 5'b01_100;
            5'd7:    r = 5'b01_010;
            5'd8:    r = 5'b10_000;
            5'd9:    r = 5'b10_011;
            5'd10:   r = 5'b10_110;
            5'd11:   r = 5'b10_100;
            5'd12:   r = 5'b10_010;
            5'd13:   r = 5'b11_000;
            5'd14:   r = 5'b11_110;
            5'd15:   r = 5'b11_100;
            5'd16:   r = 5'b11_010;
            default: r = 5'b00_000;
        endcase
        return r;
    endfunction

    function automatic logic is_term(input logic [4:0] n);
        return (n == 5'd0) || (n > 5'd16);
    endfunction

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        timer_d  = timer_q;
        addr_d   = song_addr;
        tnote_d  = target_note;
        tkeys_d  = target_keys;
        tair_d   = target_airflow;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        hits_d   = hits;
        misses_d = misses;

        timer_inc = timer_q + 1'b1;
        // A rest (0) never matches since a presented target is never 0.
        hold_inc  = (player_note == target_note) ? hold_q + 1'b1 : '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d   = '0;
                    hits_d   = '0;
                    misses_d = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (is_term(song_note)) begin
                    tnote_d = '0;
                    tkeys_d = '0;
                    tair_d  = '0;
                    state_d = S_DONE;
                end else begin
                    tnote_d            = song_note;
                    {tair_d, tkeys_d}  = map_note(song_note);
                    hold_d             = '0;
                    timer_d            = '0;
                    state_d            = S_WAIT;
                end
            end
            S_WAIT: begin
                hold_d  = hold_inc;
                timer_d = timer_inc;
                // Hit is tested first so a simultaneous timeout is dropped.
                if (hold_inc == HOLD_W'(HOLD_CYCLES)) begin
                    hit_d   = 1'b1;
                    hits_d  = (hits == 8'hFF) ? hits : hits + 8'd1;
                    state_d = S_NEXT;
                end else if (timer_inc == TIME_W'(TIMEOUT_CYCLES)) begin
                    miss_d   = 1'b1;
                    misses_d = (misses == 8'hFF) ? misses : misses + 8'd1;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (song_addr == ADDR_W'(SONG_LEN - 1)) begin
                    tnote_d = '0;
                    tkeys_d = '0;
                    tair_d  = '0;
                    state_d = S_DONE;
                end else begin
                    addr_d  = song_addr + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state.
        busy_d = (state_d == S_FETCH) || (state_d == S_WAIT)
              || (state_d == S_NEXT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            hold_q         <= '0;
            timer_q        <= '0;
            song_addr      <= '0;
            target_note    <= '0;
            target_keys    <= '0;
            target_airflow <= '0;
            hit            <= 1'b0;
            miss           <= 1'b0;
            hits           <= '0;
            misses         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            timer_q        <= timer_d;
            song_addr      <= addr_d;
            target_note    <= tnote_d;
            target_keys    <= tkeys_d;
            target_airflow <= tair_d;
            hit            <= hit_d;
            miss           <= miss_d;
            hits           <= hits_d;
            misses         <= misses_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule

// File: doc/fingering_prompter.md
# fingering_prompter

Practice-sequencer for the trumpet tool, working in the opposite direction to the note selector: it takes a target note code and drives the required valve pattern and airflow level for the player. It steps through a song of 5-bit note codes read from an external ROM, presents each target, and compares it with the player's decoded note (the note selector's `note` output). Each note is scored as a hit when the player holds it steadily for long enough, or as a miss on timeout. It sits between the song ROM, the note selector and the LED/HEX display logic.

## Interface
Parameters:
- `ADDR_W`, default 3: song address width.
- `SONG_LEN`, default 8: number of song entries, 1..2**ADDR_W.
- `HOLD_CYCLES`, default 4: consecutive matching cycles required for a hit, ≥1.
- `TIMEOUT_CYCLES`, default 1024: WAIT_MATCH cycles allowed before a miss, > HOLD_CYCLES.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start` input 1: single-cycle pulse that starts or restarts a song.
- `song_addr` output ADDR_W: ROM address, registered.
- `song_note` input 5: ROM data for `song_addr`, combinational (valid in the same cycle).
- `player_note` input 5: note code currently played.
- `target_note` output 5: current target code.
- `target_keys` output 3: valves to press, 1 = pressed, bit 2 = valve 1.
- `target_airflow` output 2: required airflow level, 00..11.
- `hit` output 1: one-cycle pulse when a note is scored as a hit.
- `miss` output 1: one-cycle pulse when a note is scored as a miss.
- `hits` output 8: hit count, saturates at 255.
- `misses` output 8: miss count, saturates at 255.
- `busy` output 1: high in FETCH, WAIT_MATCH and NEXT.
- `done` output 1: level, high in DONE.

## Operation
Note → (airflow, keys) map:
- 1→01,000; 2→01,111; 3→01,101; 4→01,011; 5→01,110; 6→01,100; 7→01,010.
- 8→10,000; 9→10,011; 10→10,110; 11→10,100; 12→10,010.
- 13→11,000; 14→11,110; 15→11,100; 16→11,010.
- 0 and 17–31 are terminators: mapped to 00,000 and never presented.

FSM states: IDLE, FETCH, WAIT_MATCH, NEXT, DONE.
- IDLE: `start` → `song_addr`=0, `hits`=`misses`=0, go to FETCH. Otherwise stay.
- FETCH (1 cycle): if `song_note` is a terminator → DONE. Else latch it into `target_note` and its mapping into `target_keys`/`target_airflow`, clear the hold and timeout counters, go to WAIT_MATCH.
- WAIT_MATCH, each cycle:
  - timer += 1.
  - If `player_note`==`target_note`, hold += 1; else hold = 0.
  - hold reaches HOLD_CYCLES → pulse `hit`, `hits`+1, go to NEXT.
  - Else timer reaches TIMEOUT_CYCLES → pulse `miss`, `misses`+1, go to NEXT.
  - Both on the same cycle → hit wins; no miss.
- NEXT (1 cycle): if `song_addr`==SONG_LEN-1 → DONE; else `song_addr`+1 → FETCH.
- DONE: `done`=1, counts held. `start` → restart exactly as from IDLE.

Other rules:
- `start` in FETCH, WAIT_MATCH or NEXT is ignored.
- Counts saturate at 255 and never wrap.
- Target outputs are 0 in IDLE and DONE. They hold their value through FETCH→WAIT_MATCH→NEXT until the next FETCH overwrites them.
- A player note of 0 (rest) never matches, because targets are never 0.

## Timing
- Reset: state IDLE; every output 0 (`song_addr`, `target_*`, `hit`, `miss`, `hits`, `misses`, `busy`, `done`). Reset mid-song aborts without scoring.
- `start` at cycle 0 → FETCH in cycle 1 with `song_addr`=0 → target outputs valid from cycle 2 (first WAIT_MATCH cycle).
- If the player matches from the first WAIT_MATCH cycle W, `hit` is high in cycle W+HOLD_CYCLES and NEXT occupies that same cycle.
- With no match, `miss` is high in cycle W+TIMEOUT_CYCLES.
- Per-note overhead beyond WAIT_MATCH: FETCH + NEXT = 2 cycles.
- `done` rises in the cycle after the last NEXT, or in the cycle after a FETCH that reads a terminator.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset asserted in WAIT_MATCH with `hits`=2 → all outputs 0 immediately (asynchronous); after release, state stays IDLE until `start`.
- Song {1,2,8,9,13,14,15,16}, player copies `target_note` with 1-cycle lag, HOLD=4 → 8 `hit` pulses, `hits`=8, `misses`=0, `done`=1. When target is 16: keys=010, airflow=11. When target is 2: keys=111, airflow=01.
- Target 5, player plays 5 for 3 cycles, then 6 for 1 cycle, then 5 for 4 cycles → hold counter restarts; `hit` fires exactly once, 4 cycles after the second run starts.
- Player holds 0 throughout, TIMEOUT=16 → `miss` arrives 16 cycles after the first WAIT_MATCH cycle for every note; `misses`=SONG_LEN.
- Song {3,7,0,...} → 2 notes scored, then `done` rises the cycle after the FETCH of addr 2, with `song_addr`=2.
- `start` pulsed mid-song → ignored. `start` in DONE → counts clear and `song_addr`=0 in the next cycle. Hit and timeout aligned on the same cycle (HOLD=4, TIMEOUT=5, match begins in the 2nd WAIT_MATCH cycle) → `hit`=1, `miss`=0.
